// File: rtl/mach_tru_pkg.sv
// Shared definitions for the 4-bit ripple subtractor (mach_tru_4bit).
package mach_tru_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // {borrow, difference} at the default operand width
  typedef logic [DEFAULT_WIDTH:0] result_t;

  // Arithmetic reference: (x - y) mod 2^(DEFAULT_WIDTH+1)
  function automatic result_t ref_diff(input logic [DEFAULT_WIDTH-1:0] x,
                                       input logic [DEFAULT_WIDTH-1:0] y);
    result_t xe;
    result_t ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return xe - ye;
  endfunction

endpackage

// File: rtl/mach_tru_4bit_full_sub.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow of a single bit position
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/mach_tru_4bit.sv
// Registered WIDTH-bit unsigned subtractor: B <= {borrow, X - Y}, one-cycle latency.
// Optional: define MACH_TRU_SIGNED_OVF_EN to add a registered signed-overflow flag ovf.
module mach_tru_4bit
  import mach_tru_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH:0]   B,
  output logic             out_valid
`ifdef MACH_TRU_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   result;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_sub u_full_sub (
      .x    (X[i]),
      .y    (Y[i]),
      .bin  (borrow[i]),
      .d    (diff[i]),
      .bout (borrow[i+1])
    );
  end

  assign result = {borrow[WIDTH], diff};

  // Result and valid registers; reset wins over in_valid, B holds when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      B         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        B <= result;
      end
    end
  end

`ifdef MACH_TRU_SIGNED_OVF_EN
  logic ovf_next;

  // Signed overflow: operand signs differ and result sign differs from X
  always_comb begin
    ovf_next = (X[WIDTH-1] != Y[WIDTH-1]) && (diff[WIDTH-1] != X[WIDTH-1]);
  end

  // Overflow flag register, same update rules as B
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_mach_tru_4bit.sv
// Directed self-checking bench for mach_tru_4bit (default and MACH_TRU_SIGNED_OVF_EN builds).
module tb_mach_tru_4bit;
  import mach_tru_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] X;
  logic [3:0] Y;
  logic [4:0] B;
  logic       out_valid;
`ifdef MACH_TRU_SIGNED_OVF_EN
  logic       ovf;
`endif

  int checks;
  int failures;

  mach_tru_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .B         (B),
    .out_valid (out_valid)
`ifdef MACH_TRU_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, advance one clock, leave time 1 unit after the edge for sampling
  task automatic step(input logic rn, input logic v, input logic [3:0] xa, input logic [3:0] ya);
    rst_n    = rn;
    in_valid = v;
    X        = xa;
    Y        = ya;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    X        = 4'd5;
    Y        = 4'd3;
    #1;

    // Reset held two cycles with valid input present
    step(1'b0, 1'b1, 4'd5, 4'd3);
    chk("rst1_B", 32'(B), 32'd0);
    chk("rst1_v", 32'(out_valid), 32'd0);
`ifdef MACH_TRU_SIGNED_OVF_EN
    chk("rst1_ovf", 32'(ovf), 32'd0);
`endif
    step(1'b0, 1'b1, 4'd5, 4'd3);
    chk("rst2_B", 32'(B), 32'd0);
    chk("rst2_v", 32'(out_valid), 32'd0);

    // Release reset: 5 - 3
    step(1'b1, 1'b1, 4'd5, 4'd3);
    chk("rel_B", 32'(B), 32'd2);
    chk("rel_v", 32'(out_valid), 32'd1);

    step(1'b1, 1'b1, 4'd2, 4'd1);
    chk("basic_B", 32'(B), 32'd1);

    step(1'b1, 1'b1, 4'd1, 4'd14);
    chk("borrow_B", 32'(B), 32'd19);
    chk("borrow_b4", 32'(B[4]), 32'd1);

    step(1'b1, 1'b1, 4'd0, 4'd15);
    chk("mostneg_B", 32'(B), 32'd17);

    step(1'b1, 1'b1, 4'd9, 4'd9);
    chk("equal_B", 32'(B), 32'd0);

    step(1'b1, 1'b1, 4'd15, 4'd0);
    chk("maxpos_B", 32'(B), 32'd15);
    chk("maxpos_v", 32'(out_valid), 32'd1);

    // Idle cycle: B holds, valid drops
    step(1'b1, 1'b0, 4'd3, 4'd7);
    chk("hold_B", 32'(B), 32'd15);
    chk("hold_v", 32'(out_valid), 32'd0);

    step(1'b1, 1'b1, 4'd4, 4'd6);
    chk("resume_B", 32'(B), 32'd30);
    chk("resume_v", 32'(out_valid), 32'd1);

    // Mid-stream reset, then release with valid low, then first operation
    step(1'b0, 1'b1, 4'd12, 4'd1);
    chk("mrst_B", 32'(B), 32'd0);
    chk("mrst_v", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 4'd12, 4'd1);
    chk("mrel_B", 32'(B), 32'd0);
    chk("mrel_v", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 4'd8, 4'd3);
    chk("mfirst_B", 32'(B), 32'd5);
    chk("mfirst_v", 32'(out_valid), 32'd1);

`ifdef MACH_TRU_SIGNED_OVF_EN
    step(1'b1, 1'b1, 4'd7, 4'd8);
    chk("ovf_7m8_B", 32'(B), 32'd31);
    chk("ovf_7m8", 32'(ovf), 32'd1);
    step(1'b1, 1'b1, 4'd8, 4'd1);
    chk("ovf_8m1_B", 32'(B), 32'd7);
    chk("ovf_8m1", 32'(ovf), 32'd1);
    step(1'b1, 1'b1, 4'd3, 4'd2);
    chk("ovf_3m2_B", 32'(B), 32'd1);
    chk("ovf_3m2", 32'(ovf), 32'd0);
    step(1'b1, 1'b0, 4'd7, 4'd8);
    chk("ovf_hold", 32'(ovf), 32'd0);
`endif

    // All 256 pairs back-to-back, one-cycle latency, continuous valid
    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 0; b < 16; b++) begin
        step(1'b1, 1'b1, a[3:0], b[3:0]);
        chk("exh_B", 32'(B), 32'(ref_diff(a[3:0], b[3:0])));
        chk("exh_v", 32'(out_valid), 32'd1);
`ifdef MACH_TRU_SIGNED_OVF_EN
        begin
          int sa;
          int sb;
          int sd;
          sa = (a >= 8) ? int'(a) - 16 : int'(a);
          sb = (b >= 8) ? int'(b) - 16 : int'(b);
          sd = sa - sb;
          chk("exh_ovf", 32'(ovf), ((sd > 7) || (sd < -8)) ? 32'd1 : 32'd0);
        end
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mach_tru_4bit.md
Name: mach_tru_4bit

Overview:
- Registered 4-bit unsigned subtractor ("mạch trừ 4 bit"): computes X − Y and outputs a 5-bit result B.
- B[3:0] is the difference and B[4] is the borrow-out, so B is also the 5-bit two's-complement value of X − Y.
- Built as a ripple chain of full-subtractor cells.
- Used as a small arithmetic leaf in datapaths that need difference plus borrow.

Parameters:
- WIDTH, 4, operand width; B is WIDTH+1 bits. All requirements below are stated for WIDTH=4 and must generalise to any WIDTH ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  X/Y are valid this cycle
- X  input  WIDTH  minuend, unsigned
- Y  input  WIDTH  subtrahend, unsigned
- B  output  WIDTH+1  registered result: {borrow, difference}
- out_valid  output  1  B holds a fresh result

Behaviour:
- Combinational core:
  - Ripple chain with bit i full-subtractor: d_i = x_i ^ y_i ^ b_i; b_{i+1} = (~x_i & y_i) | (~(x_i ^ y_i) & b_i); b_0 = 0.
  - Result = {b_WIDTH, d[WIDTH-1:0]}. This equals (X − Y) mod 2^(WIDTH+1).
  - Borrow b_WIDTH = 1 exactly when X < Y.
- Latency: one clock.
  - On a rising edge with rst_n=1 and in_valid=1: B <= result, out_valid <= 1.
  - With rst_n=1 and in_valid=0: B holds its previous value, out_valid <= 0.
- Reset:
  - On a rising edge with rst_n=0: B <= 0, out_valid <= 0, regardless of in_valid.
  - Reset has priority over in_valid.
  - Deasserting reset mid-stream: the first result appears one cycle after the first in_valid sampled with rst_n=1.
  - No output changes between clock edges.
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid.
- There is no backpressure and no handshake beyond valid.
- Boundary cases:
  - X=Y gives B=0 and borrow 0.
  - X=0, Y=2^WIDTH−1 gives the most negative result, B = 2^(WIDTH+1) − (2^WIDTH − 1); for WIDTH=4, B=5'b10001.
  - X=2^WIDTH−1, Y=0 gives B=2^WIDTH−1 with borrow 0.
- X and Y carry no X-propagation requirement when in_valid=0.

Optional Feature:
- Macro: MACH_TRU_SIGNED_OVF_EN.
- When defined:
  - Adds output ovf (1 bit, registered alongside B, reset to 0).
  - ovf = 1 when X and Y, interpreted as WIDTH-bit two's-complement values, produce a difference not representable in WIDTH bits: (x_msb ≠ y_msb) && (d_msb ≠ x_msb).
  - ovf updates under the same valid/reset rules as B.
- When undefined:
  - The port and its logic are absent.
  - B and out_valid behaviour is identical in both builds.

Decomposition:
- Package mach_tru_pkg:
  - localparam default WIDTH=4.
  - typedef for the result type logic [WIDTH:0].
  - A function computing the reference difference, used by the bench.
- Sub-module full_sub: inputs x, y, bin; outputs d, bout. It is instantiated WIDTH times by a generate loop.
- Top level holds only the chain wiring and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, X=5, Y=3 -> B=0, out_valid=0 throughout; release -> next cycle B=5'b00010, out_valid=1.
- Basic: X=2, Y=1, in_valid=1 -> one cycle later B=5'b00001 (1), borrow 0.
- Borrow: X=1, Y=14 -> B=5'b10011 (19, i.e. −13), B[4]=1; X=0, Y=15 -> B=5'b10001 (17, i.e. −15).
- Edges: X=Y=9 -> B=0; X=15, Y=0 -> B=5'b01111; in_valid dropped for one cycle -> B holds, out_valid=0.
- Exhaustive: all 256 X/Y pairs back-to-back -> every B equals (X−Y) mod 32, out_valid continuous, 1-cycle latency.
- MACH_TRU_SIGNED_OVF_EN build: X=7, Y=8 (signed 7 − (−8)) -> ovf=1; X=8, Y=1 -> ovf=1; X=3, Y=2 -> ovf=0; B unchanged versus the default build.
